// File: rtl/regfile_sort_pkg.sv
// Shared constants and types for the register-file bubble-sort sequencer.
package regfile_sort_pkg;

  localparam int N_DEF     = 8;
  localparam int W_DEF     = 4;
  localparam int IDX_W_DEF = $clog2(N_DEF);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPARE = 2'd1,
    ST_SWAP    = 2'd2,
    ST_DONE    = 2'd3
  } sort_state_e;

  typedef logic [IDX_W_DEF-1:0] idx_t;

  // Worst-case swap count of a bubble sort over n entries.
  function automatic int max_swaps(input int n);
    return n * (n - 1) / 2;
  endfunction

endpackage

// File: rtl/regfile_pair_cmp.sv
// Combinational compare of the adjacent register pair (r[idx], r[idx+1]).
module regfile_pair_cmp #(
  parameter int N     = 8,
  parameter int W     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0][W-1:0] r,
  input  logic [IDX_W-1:0]    idx,
  output logic                gt
);

  logic [W-1:0] lo_val;
  logic [W-1:0] hi_val;

  always_comb begin
    lo_val = '0;
    hi_val = '0;
    for (int k = 0; k < N - 1; k++) begin
      if (IDX_W'(k) == idx) begin
        lo_val = r[k];
        hi_val = r[k+1];
      end
    end
  end

  assign gt = (lo_val > hi_val);

endmodule

// File: rtl/register_file_swap.sv
// N x W register file with a single write port and an atomic swap of two entries.
module register_file_swap #(
  parameter int N     = 8,
  parameter int W     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [W-1:0]        wdata,
  input  logic                swapxy,
  input  logic [IDX_W-1:0]    x,
  input  logic [IDX_W-1:0]    y,
  output logic [N-1:0][W-1:0] r
);

  // A swap wins over a write landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (swapxy) begin
      r[x] <= r[y];
      r[y] <= r[x];
    end else if (we) begin
      r[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/regfile_sort_ctrl.sv
// Bubble-sort sequencer driving register_file_swap one swap at a time.
// Define SORT_EARLY_EXIT_EN to finish after the first pass that issues no swap.
//
// state   | meaning
// IDLE    | waiting for start
// COMPARE | compare pair (i, i+1), issue swap if out of order
// SWAP    | swap command on the bus for one cycle
// DONE    | one-cycle done pulse, back to IDLE
module regfile_sort_ctrl
  import regfile_sort_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int W     = W_DEF,
  parameter int IDX_W = $clog2(N),
  parameter int CNT_W = $clog2(max_swaps(N) + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [N-1:0][W-1:0] r,
  output logic                swapxy,
  output logic [IDX_W-1:0]    x,
  output logic [IDX_W-1:0]    y,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    swap_count
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] COMPARE = ST_COMPARE;
  localparam logic [1:0] SWAP    = ST_SWAP;
  localparam logic [1:0] DONE    = ST_DONE;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 2);

  logic [1:0]       state, state_nxt;
  logic [IDX_W-1:0] p, p_nxt;
  logic [IDX_W-1:0] i, i_nxt;
  logic             pass_swapped, pass_swapped_nxt;
  logic             swapxy_nxt;
  logic [IDX_W-1:0] x_nxt, y_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  logic             gt;
  logic [IDX_W-1:0] pass_end;
  logic             pass_last;
  logic             exit_now;

  regfile_pair_cmp #(
    .N     (N),
    .W     (W),
    .IDX_W (IDX_W)
  ) u_pair_cmp (
    .r   (r),
    .idx (i),
    .gt  (gt)
  );

  assign pass_end  = LAST_IDX - p;
  assign pass_last = (i >= pass_end);

`ifdef SORT_EARLY_EXIT_EN
  // From SWAP the flag is already set, so only a swap-free pass exits early.
  assign exit_now = (p >= LAST_IDX) || !pass_swapped;
`else
  assign exit_now = (p >= LAST_IDX);
`endif

  always_comb begin
    state_nxt        = state;
    p_nxt            = p;
    i_nxt            = i;
    pass_swapped_nxt = pass_swapped;
    swapxy_nxt       = 1'b0;
    x_nxt            = x;
    y_nxt            = y;
    cnt_nxt          = swap_count;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt        = COMPARE;
          p_nxt            = '0;
          i_nxt            = '0;
          pass_swapped_nxt = 1'b0;
          cnt_nxt          = '0;
        end
      end
      COMPARE, SWAP: begin
        if (state == COMPARE && gt) begin
          state_nxt        = SWAP;
          swapxy_nxt       = 1'b1;
          x_nxt            = i;
          y_nxt            = i + IDX_W'(1);
          cnt_nxt          = swap_count + CNT_W'(1);
          pass_swapped_nxt = 1'b1;
        end else if (!pass_last) begin
          state_nxt = COMPARE;
          i_nxt     = i + IDX_W'(1);
        end else if (exit_now) begin
          state_nxt = DONE;
        end else begin
          state_nxt        = COMPARE;
          p_nxt            = p + IDX_W'(1);
          i_nxt            = '0;
          pass_swapped_nxt = 1'b0;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      p            <= '0;
      i            <= '0;
      pass_swapped <= 1'b0;
      swapxy       <= 1'b0;
      x            <= '0;
      y            <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      swap_count   <= '0;
    end else begin
      state        <= state_nxt;
      p            <= p_nxt;
      i            <= i_nxt;
      pass_swapped <= pass_swapped_nxt;
      swapxy       <= swapxy_nxt;
      x            <= x_nxt;
      y            <= y_nxt;
      busy         <= (state_nxt == COMPARE) || (state_nxt == SWAP);
      done         <= (state_nxt == DONE);
      swap_count   <= cnt_nxt;
    end
  end

endmodule

// File: doc/regfile_sort_ctrl.md
Name: regfile_sort_ctrl

Overview:
- Sequencer that sits directly upstream of register_file_swap and also reads that block's register outputs.
- It bubble-sorts the N registers into ascending order. It drives the swapxy/x/y command port one swap at a time.
- A start pulse triggers a sort; done pulses when the register file holds sorted contents.

Parameters:
- N, 8, number of registers in the attached register file (≥2).
- W, 4, register data width.
- IDX_W, $clog2(N), width of the x/y index outputs.
- CNT_W, $clog2(N*(N-1)/2+1), width of swap_count.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a sort; sampled only in IDLE.
- r  in  N x W  current register contents from register_file_swap (r[0]..r[N-1]).
- swapxy  out  1  swap command to register_file_swap; registered.
- x  out  IDX_W  first swap index; registered.
- y  out  IDX_W  second swap index; registered, always x+1 when swapxy=1.
- busy  out  1  high in COMPARE and SWAP.
- done  out  1  one-cycle pulse in the DONE state.
- swap_count  out  CNT_W  swaps issued by the current/last sort.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE.
  - swapxy=0, x=0, y=0, busy=0, done=0, swap_count=0.
  - pass counter p=0, index i=0, pass-swap flag=0.
  - Reset mid-sort abandons the sort immediately; register contents are not restored.
- The register file performs the swap on the rising edge where swapxy=1. r reflects the swapped values from the next cycle.
- IDLE:
  - start=1 → COMPARE; p=0, i=0, swap_count=0, pass flag cleared.
  - Otherwise stay in IDLE.
- COMPARE, one cycle per adjacent pair (i, i+1), unsigned compare r[i] > r[i+1]:
  - True: register swapxy=1, x=i, y=i+1, swap_count+1, pass flag set → SWAP.
  - False, equal values included: no swap, so the sort is stable; advance index (below).
- SWAP, one cycle with swapxy=1:
  - The next edge clears swapxy and advances the index.
  - x/y hold their last values whenever swapxy=0.
- Index advance:
  - If i < N-2-p: i+1, → COMPARE.
  - Otherwise the pass ends. If p = N-2 → DONE. Else p+1, i=0, pass flag cleared, → COMPARE. SORT_EARLY_EXIT_EN changes this rule (see Optional Feature).
- DONE: done=1 for exactly one cycle, busy=0 → IDLE.
  - swap_count holds its value until the next accepted start.
- start while busy or in DONE is ignored; no queuing.
- r must change only through this block's swaps while busy=1. Behaviour under external writes is undefined.
- Cycle count, start sampled at edge 0:
  - COMPARE cycles = N(N-1)/2 without early exit; SWAP cycles = number of swaps.
  - DONE occupies the cycle after the last COMPARE/SWAP.
- swap_count never exceeds N(N-1)/2, so no saturation logic is needed.

Optional Feature:
- Macro SORT_EARLY_EXIT_EN.
- Defined: at the end of any pass whose pass flag is 0, go directly to DONE, skipping the remaining passes.
- Undefined: always run all N-1 passes, giving a fixed compare count regardless of data.

Decomposition:
- Package regfile_sort_pkg:
  - Default N/W constants.
  - State enum {IDLE, COMPARE, SWAP, DONE}, 2-bit encoding.
  - Index typedef logic [IDX_W-1:0].
- Sub-module regfile_pair_cmp, purely combinational:
  - Selects r[i] and r[i+1] by index.
  - Outputs gt = (r[i] > r[i+1]).
- The FSM, counters and output registers stay in regfile_sort_ctrl.
- Bench instantiates regfile_sort_ctrl together with register_file_swap, with swapxy/x/y/r connected.

Test Plan:
- Reset: hold rst_n=0 mid-cycle (async) → all outputs 0 immediately. Release, start=1 with r={0,1,...,7} sorted, macro undefined → 28 COMPARE cycles, swapxy never 1, done at cycle 29, swap_count=0.
- Same sorted input with SORT_EARLY_EXIT_EN defined → 7 compares, done at cycle 8, swap_count=0.
- Reverse input r={7,6,...,0} → 28 swaps, first command x=0 y=1, done at cycle 57 in both builds, final r={0..7}, swap_count=28.
- Duplicates r={3,3,1,1,F,0,F,2} → no swap ever issued for equal pairs, final r={0,1,1,2,3,3,F,F}.
- start pulsed while busy → ignored, exactly one done pulse; then assert rst_n=0 mid-sort at a SWAP cycle → swapxy drops asynchronously, state IDLE, a new start completes normally.
